// File: rtl/i2s_frame_scheduler.sv
// I2S2 frame sequencer: bit clock, LR clock and strobe generation, plus a
// once-per-frame round-robin arbiter that picks which stereo sample goes out.
module i2s_frame_scheduler #(
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int BIT_CYCLES = 12
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  en_in,
    input  logic                  a_valid_in,
    input  logic [2*SAMPLE_W-1:0] a_data_in,
    output logic                  a_ready_out,
    input  logic                  b_valid_in,
    input  logic [2*SAMPLE_W-1:0] b_data_in,
    output logic                  b_ready_out,
    output logic                  sclk_out,
    output logic                  lrck_out,
    output logic                  shift_out,
    output logic                  capture_out,
    output logic                  frame_start_out,
    output logic [SAMPLE_W-1:0]   tx_left_out,
    output logic [SAMPLE_W-1:0]   tx_right_out,
    output logic [1:0]            tx_src_out,
    output logic                  underrun_out,
    output logic [1:0]            state_dbg_out
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(SLOT_W);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_HALF = CW'(BIT_CYCLES / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            lrck_q, lrck_d;
    logic            sclk_q, sclk_d;
    logic            last_b_q;
    logic            frame_last;
    logic            arb;
    logic            grant_a;
    logic            grant_b;

    assign frame_last = (state_q == RUN) && lrck_q && (bit_q == BIT_LAST) && (cyc_q == CYC_LAST);

    // Round robin: on a tie the requester that did not win last time goes.
    assign grant_a = a_valid_in && (!b_valid_in || last_b_q);
    assign grant_b = b_valid_in && (!a_valid_in || !last_b_q);

    // Handshake: ready is combinational and only raised in the arbitration
    // cycle for the granted requester while its valid is high; a transfer is
    // valid && ready, sampled on the next rising clk_in.
    assign a_ready_out = arb && grant_a && rst_in;
    assign b_ready_out = arb && grant_b && rst_in;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        lrck_d  = lrck_q;
        arb     = 1'b0;
        case (state_q)
            IDLE: begin
                cyc_d  = '0;
                bit_d  = '0;
                lrck_d = 1'b0;
                if (en_in) state_d = LOAD;
            end
            LOAD: begin
                arb     = 1'b1;
                state_d = RUN;
                cyc_d   = '0;
                bit_d   = '0;
                lrck_d  = 1'b0;
            end
            RUN: begin
                if (frame_last) begin
                    cyc_d  = '0;
                    bit_d  = '0;
                    lrck_d = 1'b0;
                    if (en_in) arb = 1'b1;
                    else       state_d = IDLE;
                end else if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d  = '0;
                        lrck_d = ~lrck_q;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // sclk is registered from the next counter value so it lines up with cyc_q.
        sclk_d = (state_d == RUN) && (cyc_d >= CYC_HALF);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= IDLE;
            cyc_q           <= '0;
            bit_q           <= '0;
            lrck_q          <= 1'b0;
            sclk_q          <= 1'b0;
            last_b_q        <= 1'b1;
            frame_start_out <= 1'b0;
            underrun_out    <= 1'b0;
            tx_left_out     <= '0;
            tx_right_out    <= '0;
            tx_src_out      <= 2'b00;
        end else begin
            state_q         <= state_d;
            cyc_q           <= cyc_d;
            bit_q           <= bit_d;
            lrck_q          <= lrck_d;
            sclk_q          <= sclk_d;
            frame_start_out <= arb;
            underrun_out    <= arb && !a_valid_in && !b_valid_in;
            if (arb) begin
                if (grant_a) begin
                    tx_left_out  <= a_data_in[2*SAMPLE_W-1:SAMPLE_W];
                    tx_right_out <= a_data_in[SAMPLE_W-1:0];
                    tx_src_out   <= 2'b01;
                    last_b_q     <= 1'b0;
                end else if (grant_b) begin
                    tx_left_out  <= b_data_in[2*SAMPLE_W-1:SAMPLE_W];
                    tx_right_out <= b_data_in[SAMPLE_W-1:0];
                    tx_src_out   <= 2'b10;
                    last_b_q     <= 1'b1;
                end else begin
                    tx_left_out  <= '0;
                    tx_right_out <= '0;
                    tx_src_out   <= 2'b00;
                end
            end
        end
    end

    assign sclk_out      = sclk_q;
    assign lrck_out      = lrck_q;
    assign shift_out     = (state_q == RUN) && (cyc_q == '0);
    assign capture_out   = (state_q == RUN) && (cyc_q == CYC_HALF);
    assign state_dbg_out = state_q;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Bench for i2s_frame_scheduler: arbitration vector table, multi-cycle corner
// sequences, and a frame-position reference model checking every cycle.
module tb_i2s_frame_scheduler;

    localparam int SW    = 24;
    localparam int SLOTS = 32;
    localparam int BC    = 12;
    localparam int FRAME = 2 * SLOTS * BC;
    localparam int LIMIT = 2 * FRAME + 100;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            en_in;
    logic            a_valid_in, b_valid_in;
    logic [2*SW-1:0] a_data_in, b_data_in;
    logic            a_ready_out, b_ready_out;
    logic            sclk_out, lrck_out, shift_out, capture_out;
    logic            frame_start_out, underrun_out;
    logic [SW-1:0]   tx_left_out, tx_right_out;
    logic [1:0]      tx_src_out;
    logic [1:0]      state_dbg_out;
    logic [59:0]     dut_v;

    i2s_frame_scheduler #(.SAMPLE_W(SW), .SLOT_W(SLOTS), .BIT_CYCLES(BC)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in),
        .a_valid_in(a_valid_in), .a_data_in(a_data_in), .a_ready_out(a_ready_out),
        .b_valid_in(b_valid_in), .b_data_in(b_data_in), .b_ready_out(b_ready_out),
        .sclk_out(sclk_out), .lrck_out(lrck_out), .shift_out(shift_out),
        .capture_out(capture_out), .frame_start_out(frame_start_out),
        .tx_left_out(tx_left_out), .tx_right_out(tx_right_out),
        .tx_src_out(tx_src_out), .underrun_out(underrun_out),
        .state_dbg_out(state_dbg_out)
    );

    assign dut_v = {a_ready_out, b_ready_out, sclk_out, lrck_out, shift_out, capture_out,
                    frame_start_out, underrun_out, tx_src_out, tx_left_out, tx_right_out,
                    state_dbg_out};

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;

    initial forever begin
        @(posedge clk_in);
        cyc_no++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, run incomplete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode 0 idle, 1 load, 2 run; m_t is the position inside the current frame.
    int              m_mode = 0;
    int              m_t    = 0;
    logic [SW-1:0]   m_left = '0, m_right = '0;
    logic [1:0]      m_src  = 2'b00;
    logic            m_last_b = 1'b1;
    logic            m_fs = 1'b0, m_ur = 1'b0;
    logic            m_run, m_arb, m_ga, m_gb;
    int              m_ph;
    logic [59:0]     exp_v;

    initial forever begin
        @(negedge clk_in);
        if (!rst_in) begin
            m_mode = 0; m_t = 0; m_left = '0; m_right = '0; m_src = 2'b00;
            m_last_b = 1'b1; m_fs = 1'b0; m_ur = 1'b0;
        end else begin
            m_run = (m_mode == 2);
            m_ph  = m_t % BC;
            m_arb = (m_mode == 1) || (m_run && m_t == FRAME - 1 && en_in);
            m_ga  = a_valid_in && (!b_valid_in || m_last_b);
            m_gb  = b_valid_in && (!a_valid_in || !m_last_b);
            exp_v = {m_arb && m_ga, m_arb && m_gb, m_run && (m_ph >= BC / 2),
                     m_run && (m_t >= FRAME / 2), m_run && (m_ph == 0),
                     m_run && (m_ph == BC / 2), m_fs, m_ur, m_src, m_left, m_right,
                     2'(m_mode)};
            check("model_cycle", dut_v, exp_v);
            m_fs = 1'b0;
            m_ur = 1'b0;
            if (m_arb) begin
                m_fs = 1'b1; m_mode = 2; m_t = 0;
                if (m_ga) begin
                    m_left = a_data_in[2*SW-1:SW]; m_right = a_data_in[SW-1:0];
                    m_src = 2'b01; m_last_b = 1'b0;
                end else if (m_gb) begin
                    m_left = b_data_in[2*SW-1:SW]; m_right = b_data_in[SW-1:0];
                    m_src = 2'b10; m_last_b = 1'b1;
                end else begin
                    m_left = '0; m_right = '0; m_src = 2'b00; m_ur = 1'b1;
                end
            end else if (m_mode == 0) begin
                if (en_in) m_mode = 1;
            end else if (m_run) begin
                if (m_t == FRAME - 1) begin
                    m_mode = 0; m_t = 0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Advance to the next arbitration cycle as predicted by the model.
    task automatic wait_arb();
        int n = 0;
        while (!(m_mode == 1 || (m_mode == 2 && m_t == FRAME - 1)) && n < LIMIT) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= LIMIT) begin
            n_fail++;
            $display("FAIL wait_arb: waited %0d cycles, required fewer than %0d", n, LIMIT);
        end
    endtask

    typedef struct {
        logic            av;
        logic            bv;
        logic [2*SW-1:0] ad;
        logic [2*SW-1:0] bd;
        logic            ra;
        logic            rb;
        logic [1:0]      src;
        logic [SW-1:0]   l;
        logic [SW-1:0]   r;
        logic            ur;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int prev_ready;
        int k, rises, runs, shifts, caps, readies;
        logic prev_sclk;
        logic [63:0] rnd;

        // last grant starts at B, so the first tie goes to A
        vecs[0] = '{1'b1, 1'b0, 48'hF0AA11_123456, 48'h0,             1'b1, 1'b0, 2'b01, 24'hF0AA11, 24'h123456, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 48'h111111_222222, 48'hAAAAAA_BBBBBB, 1'b0, 1'b1, 2'b10, 24'hAAAAAA, 24'hBBBBBB, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 48'h333333_444444, 48'hCCCCCC_DDDDDD, 1'b1, 1'b0, 2'b01, 24'h333333, 24'h444444, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 48'h0,             48'h0,             1'b0, 1'b0, 2'b00, 24'h0,      24'h0,      1'b1};
        vecs[4] = '{1'b1, 1'b1, 48'h555555_666666, 48'hEEEEEE_FFFFFF, 1'b0, 1'b1, 2'b10, 24'hEEEEEE, 24'hFFFFFF, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 48'h0,             48'h123ABC_456DEF, 1'b0, 1'b1, 2'b10, 24'h123ABC, 24'h456DEF, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 48'h777777_888888, 48'h999999_000001, 1'b1, 1'b0, 2'b01, 24'h777777, 24'h888888, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 48'hABCDEF_FEDCBA, 48'h0,             1'b1, 1'b0, 2'b01, 24'hABCDEF, 24'hFEDCBA, 1'b0};

        rst_in = 1'b1; en_in = 1'b0;
        a_valid_in = 1'b0; b_valid_in = 1'b0; a_data_in = '0; b_data_in = '0;
        #2 rst_in = 1'b0;
        #1 check("reset_async_outputs", dut_v, 60'h0);
        repeat (3) tick();
        check("reset_held_outputs", dut_v, 60'h0);
        rst_in = 1'b1;
        en_in  = 1'b1;

        // Arbitration vector table, one entry per frame boundary
        for (int i = 0; i < 8; i++) begin
            wait_arb();
            a_valid_in = vecs[i].av; b_valid_in = vecs[i].bv;
            a_data_in  = vecs[i].ad; b_data_in  = vecs[i].bd;
            @(negedge clk_in);
            check($sformatf("vec%0d_a_ready", i), a_ready_out, vecs[i].ra);
            check($sformatf("vec%0d_b_ready", i), b_ready_out, vecs[i].rb);
            tick();
            a_valid_in = 1'b0; b_valid_in = 1'b0;
            rnd = {$urandom(), $urandom()}; a_data_in = rnd[2*SW-1:0];
            rnd = {$urandom(), $urandom()}; b_data_in = rnd[2*SW-1:0];
            @(negedge clk_in);
            check($sformatf("vec%0d_frame_start", i), frame_start_out, 1'b1);
            check($sformatf("vec%0d_tx_src", i), tx_src_out, vecs[i].src);
            check($sformatf("vec%0d_tx_left", i), tx_left_out, vecs[i].l);
            check($sformatf("vec%0d_tx_right", i), tx_right_out, vecs[i].r);
            check($sformatf("vec%0d_underrun", i), underrun_out, vecs[i].ur);
            if (i == 0) begin
                k = 0; rises = 0; prev_sclk = sclk_out;
                while (!lrck_out && k < FRAME) begin
                    @(negedge clk_in);
                    k++;
                    if (sclk_out && !prev_sclk) rises++;
                    prev_sclk = sclk_out;
                end
                check("lrck_rise_delay", k, FRAME / 2);
                check("sclk_rises_left_slot", rises, SLOTS);
            end
        end

        // B valid only in the last cycle of a frame
        wait_arb();
        b_valid_in = 1'b1; b_data_in = 48'h5A5A5A_A5A5A5;
        @(negedge clk_in);
        check("late_b_ready", b_ready_out, 1'b1);
        check("late_b_a_ready", a_ready_out, 1'b0);
        tick();
        b_valid_in = 1'b0;
        @(negedge clk_in);
        check("late_b_src", tx_src_out, 2'b10);
        check("late_b_left", tx_left_out, 24'h5A5A5A);

        // en_in dropped 100 cycles into a frame
        wait_arb();
        tick();
        runs = 0; shifts = 0; caps = 0; readies = 0;
        for (int j = 0; j < FRAME + 40; j++) begin
            if (j == 100) begin
                en_in = 1'b0; a_valid_in = 1'b1; b_valid_in = 1'b1;
            end
            @(negedge clk_in);
            if (state_dbg_out == 2'd2) runs++;
            if (shift_out) shifts++;
            if (capture_out) caps++;
            if (a_ready_out || b_ready_out) readies++;
            tick();
        end
        check("en_drop_run_cycles", runs, FRAME);
        check("en_drop_shifts", shifts, 2 * SLOTS);
        check("en_drop_captures", caps, 2 * SLOTS);
        check("en_drop_readies", readies, 0);
        check("en_drop_idle_pins", {sclk_out, lrck_out, shift_out, capture_out, state_dbg_out}, 6'h0);

        // Reset asserted inside an arbitration cycle with A pending
        a_valid_in = 1'b0; b_valid_in = 1'b0; en_in = 1'b1;
        wait_arb();
        tick();
        repeat (200) tick();
        a_valid_in = 1'b1; a_data_in = 48'h0F0F0F_F0F0F0;
        wait_arb();
        #1 rst_in = 1'b0;
        #1 check("mid_frame_async_reset", dut_v, 60'h0);
        repeat (2) tick();
        a_valid_in = 1'b1; b_valid_in = 1'b1;
        a_data_in = 48'h000AAA_000AAA; b_data_in = 48'h000BBB_000BBB;
        rst_in = 1'b1;

        // Both requesters held valid for four frames
        prev_ready = 0;
        for (int i = 0; i < 4; i++) begin
            wait_arb();
            @(negedge clk_in);
            check($sformatf("rr%0d_not_both", i), a_ready_out && b_ready_out, 1'b0);
            check($sformatf("rr%0d_grant", i), {a_ready_out, b_ready_out},
                  (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0) check($sformatf("rr%0d_ready_gap", i), cyc_no - prev_ready, FRAME);
            prev_ready = cyc_no;
            tick();
        end

        // Randomised traffic against the model
        for (int j = 0; j < 8000; j++) begin
            a_valid_in = 1'($urandom_range(0, 1));
            b_valid_in = 1'($urandom_range(0, 1));
            rnd = {$urandom(), $urandom()}; a_data_in = rnd[2*SW-1:0];
            rnd = {$urandom(), $urandom()}; b_data_in = rnd[2*SW-1:0];
            if ($urandom_range(0, 599) == 0) en_in = ~en_in;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
- Sequences the Pmod I2S2 datapath: generates the serial bit clock (sclk), left/right clock (lrck), and bit-level shift/capture strobes from the system clock.
- Shares the single line-out sample slot between two stereo sample requesters (A, B) using round-robin arbitration once per frame, with a valid/ready handshake.
- Sits between the audio producers (vocoder synth path, passthrough path) and the I2S2 serializer/deserializer.

Parameters:
- SAMPLE_W, 24, audio sample width per channel (bits).
- SLOT_W, 32, sclk periods per channel slot; must be >= SAMPLE_W.
- BIT_CYCLES, 12, system clocks per sclk period; must be even and >= 4.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-low.
- en_in  input  1  run enable.
- a_valid_in  input  1  requester A has a stereo sample.
- a_data_in  input  2*SAMPLE_W  requester A sample: {left, right}.
- a_ready_out  output  1  A's sample accepted this cycle.
- b_valid_in  input  1  requester B has a stereo sample.
- b_data_in  input  2*SAMPLE_W  requester B sample: {left, right}.
- b_ready_out  output  1  B's sample accepted this cycle.
- sclk_out  output  1  I2S bit clock.
- lrck_out  output  1  0 = left slot, 1 = right slot.
- shift_out  output  1  1-cycle pulse: datapath drives next tx bit (sclk falling edge).
- capture_out  output  1  1-cycle pulse: datapath samples rx bit (sclk rising edge).
- frame_start_out  output  1  1-cycle pulse on the first cycle of each frame.
- tx_left_out  output  SAMPLE_W  left sample for the current frame.
- tx_right_out  output  SAMPLE_W  right sample for the current frame.
- tx_src_out  output  2  source of the current frame: 00 none, 01 A, 10 B.
- underrun_out  output  1  1-cycle pulse: no requester valid at load.

Behaviour:
- Reset (rst_in low, async):
  - All outputs 0; state IDLE; counters 0.
  - last_grant = B, so A wins the first tie.
- Counters:
  - cyc_cnt 0..BIT_CYCLES-1 and bit_idx 0..SLOT_W-1.
  - lrck register toggles when bit_idx wraps.
  - Frame length = 2*SLOT_W*BIT_CYCLES cycles (768 at defaults).
- sclk_out: 0 while cyc_cnt < BIT_CYCLES/2, else 1. Registered, so no glitches.
- Strobes:
  - shift_out = 1 when cyc_cnt == 0.
  - capture_out = 1 when cyc_cnt == BIT_CYCLES/2.
  - Both only in RUN.
- State IDLE:
  - sclk, lrck, and strobes low.
  - en_in = 1 -> LOAD.
- State LOAD (1 cycle): perform arbitration, then -> RUN with all counters at 0.
- State RUN:
  - Counters advance every cycle.
  - Last cycle of frame = (lrck = 1, bit_idx = SLOT_W-1, cyc_cnt = BIT_CYCLES-1).
  - On that cycle, if en_in = 1: arbitrate and wrap counters to 0, staying in RUN.
  - On that cycle, if en_in = 0: -> IDLE.
  - Dropping en_in mid-frame never truncates a frame.
- Arbitration (LOAD cycle or last cycle of frame, en_in = 1):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the one that is not last_grant; update last_grant.
  - Neither valid: tx_left/right <= 0, tx_src <= 00, underrun_out pulses on the next cycle; last_grant unchanged.
- Handshake:
  - x_ready_out is combinational: 1 only in the arbitration cycle, for the granted requester, and only when x_valid_in = 1.
  - Transfer occurs when valid & ready.
  - At most one ready per frame.
  - Valid may be asserted first in the arbitration cycle itself.
- Latency:
  - Granted data appears on tx_left_out/tx_right_out and tx_src_out the cycle after the handshake.
  - frame_start_out pulses in that same cycle.
  - Outputs hold for the whole frame.
- Unaffected outputs: tx_* hold their last value through IDLE.
- Reset mid-frame:
  - Immediate return to the reset state.
  - Any pending handshake is dropped; a ready must not coincide with rst_in low.

Test Plan:
- Reset, en_in = 1, A valid only with a_data = {24'hF0AA11, 24'h123456}:
  - a_ready pulses once in LOAD.
  - Next cycle: frame_start = 1, tx_left = F0AA11, tx_right = 123456, tx_src = 01.
  - sclk period is 12 cycles; lrck rises 384 cycles after frame_start.
- A and B held valid for 4 frames:
  - Grants go A, B, A, B.
  - Ready pulses are exactly 768 cycles apart; never both ready in one cycle.
- Neither valid at a frame boundary:
  - tx_left = tx_right = 0, tx_src = 00.
  - underrun_out pulses for 1 cycle; no ready asserted.
- en_in dropped 100 cycles into a frame:
  - Frame runs to its full 768 cycles, then IDLE.
  - sclk = lrck = 0; no further strobes or ready.
- rst_in driven low mid-frame:
  - All outputs 0 asynchronously (before the next clock edge).
  - After release with both valid, the first grant goes to A.
- B valid asserted only in the last cycle of frame N:
  - b_ready = 1 in that cycle.
  - Frame N+1 has tx_src = 10.
